td4_core_param: RTL and testbench
=================================

Name: td4_core_param

Overview:
- Parametrised successor of the team's 4-bit TD4 CPU core; same 12-instruction ISA (4-bit opcode plus DATA_W-bit immediate), generalised to DATA_W-bit registers and a PC_W-bit program counter.
- Adds an instruction-valid stall handshake, a one-cycle output strobe and an observable carry flag.
- An optional HALT instruction is available behind a macro.
- Sits between the instruction ROM (address/instr) and the board I/O ports.

Parameters:
- DATA_W, 4, width of A, B, OUT, IN, immediate and ALU; legal range 4..16.
- PC_W, 4, program counter / ROM address width; legal only when PC_W <= DATA_W (elaboration error otherwise).

Ports:
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- address  output  PC_W  ROM address; equals PC
- instr  input  4+DATA_W  fetched instruction; op = instr[DATA_W+3:DATA_W], im = instr[DATA_W-1:0]
- instr_valid  input  1  instr is valid this cycle; when low the core stalls
- in  input  DATA_W  input port
- out  output  DATA_W  output port register
- out_strobe  output  1  one-cycle pulse in the cycle after out is written
- carry  output  1  carry flag C
- halted  output  1  core is in HALT state (always 0 without the macro)

Behaviour:
- Reset: clocked by clk while reset=1.
  - PC, A, B, out, C, out_strobe and halted all clear to 0.
  - State goes to RUN.
  - Reset has priority over instr_valid and over the HALT state, and aborts any instruction in flight.
- Execution: single cycle. On a rising edge in RUN with instr_valid=1, exactly one instruction retires.
- Stall: in RUN with instr_valid=0, no architectural state changes (PC, A, B, out, C hold) and out_strobe=0.
- ALU: {cout, sum} = src + im, computed at DATA_W+1 bits.
  - Register results wrap modulo 2^DATA_W.
  - On every retired instruction, C <= cout.
- Instruction set (op: effect; all non-jump opcodes set PC <= PC+1):
  - 0000 ADD A,im: A <= A+im
  - 0001 MOV A,B: A <= B+im
  - 0010 IN A: A <= in+im
  - 0011 MOV A,im: A <= 0+im
  - 0100 MOV B,A: B <= A+im
  - 0101 ADD B,im: B <= B+im
  - 0110 IN B: B <= in+im
  - 0111 MOV B,im: B <= 0+im
  - 1001 OUT B: out <= B+im
  - 1011 OUT im: out <= 0+im
  - 1110 JNC im: src=0 (so C <= 0). If C was 0 before this instruction, PC <= im[PC_W-1:0]; otherwise PC <= PC+1.
  - 1111 JMP im: src=0, C <= 0, PC <= im[PC_W-1:0]
  - 1000, 1010, 1100, 1101: NOP. PC <= PC+1, C <= 0, no other change (1101 is HALT only with the macro).
- PC wrap: PC+1 wraps from 2^PC_W-1 to 0.
- Jump target: im bits above PC_W are ignored.
- out_strobe: set to 1 on the edge that retires an OUT; cleared on the next edge. Back-to-back OUTs hold it high for consecutive cycles.
- JNC reads the C value produced by the previous retired instruction. Stall cycles do not disturb C.

Optional Feature:
- Macro: TD4_HALT_EN.
- Defined: opcode 1101 is HALT.
  - On retire: PC <= PC+1, C <= 0, state goes to HALT, halted=1.
  - In HALT, all architectural state freezes regardless of instr_valid; address holds at PC; out_strobe=0.
  - Only reset leaves HALT.
- Undefined: 1101 is a NOP, there is no HALT state, and halted is tied to 0.

Test Plan:
- Reset and arithmetic, DATA_W=4, instr_valid=1:
  - Program MOV A,3; ADD A,14; JNC 0; OUT im 5.
  - Cycle-by-cycle expectations: A=3, then A=1 with C=1, then the JNC falls through to PC=3, then out=5 with out_strobe high for exactly one cycle.
- Wrap/jump, DATA_W=8, PC_W=4:
  - JMP 0xF7 jumps to PC=7.
  - Sequential fetch from PC=15 wraps to PC=0.
  - MOV B,0xFF; ADD B,1 gives B=0x00 and C=1.
- I/O: in=0x5, IN A,2 -> A=7; MOV B,A; OUT B,0 -> out=7, strobe one cycle.
- Stall: deassert instr_valid for 3 cycles in the middle of ADD A,1 sequences.
  - PC, A, C and out are unchanged during the stall.
  - The count resumes exactly after the stall with no skipped or duplicated instruction.
- Reset mid-operation: assert reset for one cycle during a stall and during an OUT.
  - All outputs are 0 on the next cycle.
  - Execution restarts at PC=0.
- TD4_HALT_EN:
  - 1101 retires: halted=1, PC frozen at halt address+1, instr_valid toggling has no effect.
  - reset clears halted.
  - With the macro undefined, 1101 advances PC and halted stays 0.

Source files
------------

// File: rtl/td4_core_param.sv
// Parametrised TD4 core: single-cycle execute, instr_valid stall, one-cycle OUT strobe, visible carry.
// Define TD4_HALT_EN to make opcode 1101 a HALT that freezes the core until reset.
module td4_core_param #(
  parameter int DATA_W = 4,
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   address,
  input  logic [DATA_W+3:0] instr,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              out_strobe,
  output logic              carry,
  output logic              halted
);

  if (DATA_W < 4 || DATA_W > 16) begin : g_bad_data_w
    $error("td4_core_param: DATA_W must lie in 4..16");
  end
  if (PC_W > DATA_W) begin : g_bad_pc_w
    $error("td4_core_param: PC_W must not exceed DATA_W");
  end

  localparam logic [3:0] OP_ADD_A = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A  = 4'b0010;
  localparam logic [3:0] OP_MOV_A = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B = 4'b0101;
  localparam logic [3:0] OP_IN_B  = 4'b0110;
  localparam logic [3:0] OP_MOV_B = 4'b0111;
  localparam logic [3:0] OP_OUT_B = 4'b1001;
  localparam logic [3:0] OP_OUT_I = 4'b1011;
  localparam logic [3:0] OP_JNC   = 4'b1110;
  localparam logic [3:0] OP_JMP   = 4'b1111;
`ifdef TD4_HALT_EN
  localparam logic [3:0] OP_HALT  = 4'b1101;
`endif

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              c_q, c_d;
  logic              out_strobe_q, out_strobe_d;
  logic              run;

`ifdef TD4_HALT_EN
  typedef enum logic {S_RUN, S_HALT} state_t;
  state_t state_q, state_d;
  assign run    = (state_q == S_RUN);
  assign halted = (state_q == S_HALT);
`else
  assign run    = 1'b1;
  assign halted = 1'b0;
`endif

  logic [3:0]        op;
  logic [DATA_W-1:0] im;
  logic [DATA_W-1:0] src;
  logic [DATA_W:0]   sum;

  assign op = instr[DATA_W+3:DATA_W];
  assign im = instr[DATA_W-1:0];

  // Source operand select; jumps and NOPs add to zero so their carry is always 0.
  always_comb begin
    src = '0;
    case (op)
      OP_ADD_A, OP_MOV_BA:            src = a_q;
      OP_MOV_AB, OP_ADD_B, OP_OUT_B:  src = b_q;
      OP_IN_A, OP_IN_B:               src = in;
      default:                        src = '0;
    endcase
    sum = {1'b0, src} + {1'b0, im};
  end

  always_comb begin
    pc_d         = pc_q;
    a_d          = a_q;
    b_d          = b_q;
    out_d        = out_q;
    c_d          = c_q;
    out_strobe_d = 1'b0;
`ifdef TD4_HALT_EN
    state_d      = state_q;
`endif
    if (run && instr_valid) begin
      pc_d = pc_q + PC_ONE;
      c_d  = sum[DATA_W];
      case (op)
        OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_A: a_d = sum[DATA_W-1:0];
        OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_B: b_d = sum[DATA_W-1:0];
        OP_OUT_B, OP_OUT_I: begin
          out_d        = sum[DATA_W-1:0];
          out_strobe_d = 1'b1;
        end
        // JNC tests the carry left by the previous retired instruction.
        OP_JNC: if (!c_q) pc_d = im[PC_W-1:0];
        OP_JMP: pc_d = im[PC_W-1:0];
`ifdef TD4_HALT_EN
        OP_HALT: state_d = S_HALT;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      out_q        <= '0;
      c_q          <= 1'b0;
      out_strobe_q <= 1'b0;
`ifdef TD4_HALT_EN
      state_q      <= S_RUN;
`endif
    end else begin
      pc_q         <= pc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      out_q        <= out_d;
      c_q          <= c_d;
      out_strobe_q <= out_strobe_d;
`ifdef TD4_HALT_EN
      state_q      <= state_d;
`endif
    end
  end

  assign address    = pc_q;
  assign out        = out_q;
  assign out_strobe = out_strobe_q;
  assign carry      = c_q;

endmodule

// File: tb/tb_td4_core_param.sv
// Directed bench for td4_core_param: a 4-bit instance and an 8-bit/PC_W=4 instance fed from bench ROMs.
module tb_td4_core_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // 4-bit instance
  logic        rst4, iv4, stb4, c4, h4;
  logic [3:0]  in4, addr4, out4;
  logic [7:0]  instr4;
  logic [7:0]  rom4 [16];
  assign instr4 = rom4[addr4];

  td4_core_param #(.DATA_W(4), .PC_W(4)) u_dut4 (
    .clk(clk), .reset(rst4), .address(addr4), .instr(instr4), .instr_valid(iv4),
    .in(in4), .out(out4), .out_strobe(stb4), .carry(c4), .halted(h4)
  );

  // 8-bit instance
  logic        rst8, iv8, stb8, c8, h8;
  logic [7:0]  in8, out8;
  logic [3:0]  addr8;
  logic [11:0] instr8;
  logic [11:0] rom8 [16];
  assign instr8 = rom8[addr8];

  td4_core_param #(.DATA_W(8), .PC_W(4)) u_dut8 (
    .clk(clk), .reset(rst8), .address(addr8), .instr(instr8), .instr_valid(iv8),
    .in(in8), .out(out8), .out_strobe(stb8), .carry(c8), .halted(h8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom8();
    for (int i = 0; i < 16; i++) rom8[i] = 12'h800;
  endtask

  task automatic reset8();
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom4[i] = 8'h80;
    rom4[0] = 8'h33;  // MOV A,3
    rom4[1] = 8'h0E;  // ADD A,14
    rom4[2] = 8'hE0;  // JNC 0
    rom4[3] = 8'hB5;  // OUT 5
    rom4[4] = 8'h40;  // MOV B,A
    rom4[5] = 8'h90;  // OUT B
    rom4[6] = 8'hF6;  // JMP 6
    clear_rom8();
    rst4 = 1'b1; rst8 = 1'b1; iv4 = 1'b1; iv8 = 1'b1; in4 = 4'h0; in8 = 8'h00;
    tick();
    tick();

    check("rst4_addr", addr4, 0);
    check("rst4_out", out4, 0);
    check("rst4_stb", stb4, 0);
    check("rst4_c", c4, 0);
    check("rst4_halt", h4, 0);
    check("rst8_addr", addr8, 0);

    // Arithmetic and carry on the 4-bit core
    rst4 = 1'b0;
    tick(); check("w4_mov_addr", addr4, 1); check("w4_mov_c", c4, 0);
    tick(); check("w4_add_addr", addr4, 2); check("w4_add_c", c4, 1);
    tick(); check("w4_jnc_fall", addr4, 3); check("w4_jnc_c", c4, 0);
    tick(); check("w4_out_addr", addr4, 4); check("w4_out", out4, 5); check("w4_out_stb", stb4, 1);
    tick(); check("w4_stb_clr", stb4, 0); check("w4_out_hold", out4, 5);
    tick(); check("w4_outb_a1", out4, 1); check("w4_outb_stb", stb4, 1);
    tick(); check("w4_jmp_self", addr4, 6); check("w4_jmp_stb", stb4, 0);

    // Jump masking, wrap, carry and I/O on the 8-bit core
    clear_rom8();
    rom8[0]  = 12'hFF7;  // JMP 0xF7 -> 7
    rom8[7]  = 12'h7FF;  // MOV B,0xFF
    rom8[8]  = 12'h501;  // ADD B,1
    rom8[9]  = 12'h910;  // OUT B,0x10
    rom8[10] = 12'h202;  // IN A,2
    rom8[11] = 12'h400;  // MOV B,A
    rom8[12] = 12'h900;  // OUT B,0
    rom8[13] = 12'hE0F;  // JNC 15
    rom8[15] = 12'h001;  // ADD A,1
    in8 = 8'h05;
    reset8();
    tick(); check("w8_jmp_mask", addr8, 7); check("w8_jmp_c", c8, 0);
    tick(); check("w8_movb_addr", addr8, 8);
    tick(); check("w8_addb_addr", addr8, 9); check("w8_addb_c", c8, 1);
    tick(); check("w8_b_wrap", out8, 8'h10); check("w8_outb_stb", stb8, 1); check("w8_outb_c", c8, 0);
    tick(); check("w8_in_addr", addr8, 11); check("w8_in_stb", stb8, 0);
    tick(); check("w8_movba_addr", addr8, 12);
    tick(); check("w8_io_out", out8, 8'h07); check("w8_io_stb", stb8, 1);
    tick(); check("w8_jnc_taken", addr8, 15); check("w8_jnc_stb", stb8, 0);
    tick(); check("w8_pc_wrap", addr8, 0); check("w8_wrap_c", c8, 0);

    // Stall
    clear_rom8();
    rom8[0] = 12'hBAA;  // OUT 0xAA
    rom8[1] = 12'h3FE;  // MOV A,0xFE
    rom8[2] = 12'h001;  // ADD A,1
    rom8[3] = 12'h001;
    rom8[4] = 12'h001;
    rom8[5] = 12'h400;  // MOV B,A
    rom8[6] = 12'h900;  // OUT B
    rom8[7] = 12'hF07;  // JMP 7
    reset8();
    check("st_rst_out", out8, 0);
    tick(); check("st_out_aa", out8, 8'hAA); check("st_out_stb", stb8, 1);
    iv8 = 1'b0;
    tick(); check("st_stb_drop", stb8, 0); check("st_pc_hold0", addr8, 1);
    iv8 = 1'b1;
    tick(); check("st_mov_addr", addr8, 2);
    tick(); check("st_add1_c", c8, 0);
    tick(); check("st_add2_addr", addr8, 4); check("st_add2_c", c8, 1);
    iv8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_pc_hold", addr8, 4);
      check("st_c_hold", c8, 1);
      check("st_out_hold", out8, 8'hAA);
      check("st_stb_low", stb8, 0);
    end
    iv8 = 1'b1;
    tick(); check("st_resume_addr", addr8, 5); check("st_resume_c", c8, 0);
    tick(); check("st_movba_addr", addr8, 6);
    tick(); check("st_count", out8, 8'h01); check("st_count_stb", stb8, 1);
    tick(); check("st_end_stb", stb8, 0);

    // Reset during a stall, then during an OUT
    reset8();
    for (int i = 0; i < 4; i++) tick();
    check("rs_pre_addr", addr8, 4); check("rs_pre_c", c8, 1);
    iv8 = 1'b0;
    tick();
    rst8 = 1'b1;
    tick();
    check("rs_stall_addr", addr8, 0); check("rs_stall_out", out8, 0);
    check("rs_stall_c", c8, 0); check("rs_stall_stb", stb8, 0); check("rs_stall_h", h8, 0);
    rst8 = 1'b0; iv8 = 1'b1;
    tick(); check("rs_restart_addr", addr8, 1); check("rs_restart_out", out8, 8'hAA);
    for (int i = 0; i < 5; i++) tick();
    check("rs_at_out", addr8, 6);
    rst8 = 1'b1;
    tick();
    check("rs_out_abort", out8, 0); check("rs_out_stb", stb8, 0); check("rs_out_addr", addr8, 0);
    rst8 = 1'b0;
    tick(); check("rs_out_restart", out8, 8'hAA); check("rs_out_rstb", stb8, 1);

    // Opcode 1101
    clear_rom8();
    rom8[0] = 12'h7FF;  // MOV B,0xFF
    rom8[1] = 12'h501;  // ADD B,1 -> C=1
    rom8[2] = 12'hD00;  // HALT / NOP
    rom8[3] = 12'hB09;  // OUT 9
    rom8[4] = 12'hF04;  // JMP 4
    reset8();
    tick();
    tick(); check("h_pre_c", c8, 1);
    tick(); check("h_addr", addr8, 3); check("h_c", c8, 0);
`ifdef TD4_HALT_EN
    check("h_halted", h8, 1);
    for (int i = 0; i < 4; i++) begin
      iv8 = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check("h_frozen_addr", addr8, 3);
      check("h_frozen_h", h8, 1);
      check("h_frozen_out", out8, 0);
      check("h_frozen_stb", stb8, 0);
    end
    iv8 = 1'b1;
    rst8 = 1'b1;
    tick(); check("h_rst_h", h8, 0); check("h_rst_addr", addr8, 0);
    rst8 = 1'b0;
    tick(); check("h_rerun_addr", addr8, 1); check("h_rerun_h", h8, 0);
`else
    check("h_nop_halted", h8, 0);
    tick(); check("h_nop_addr", addr8, 4); check("h_nop_out", out8, 9); check("h_nop_stb", stb8, 1);
    check("h_nop_h", h8, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
